// File: rtl/cache_perf_counters.sv
// Multi-channel event-counter bank for the L1 cache subsystem.
// Saturating or wrapping live counters, shadow snapshot and a registered read port.
module cache_perf_counters #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 1,
  parameter int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] evt_i,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic              snap_i,
  input  logic              rd_en_i,
  input  logic              rd_src_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic              snap_valid_o
);

  logic [CNT_W-1:0] cnt    [NUM_CH];
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] rd_mux;

  // Unmatched select values (>= NUM_CH) fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (rd_sel_i == SEL_W'(k)) begin
        rd_mux = rd_src_i ? shadow[k] : cnt[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cnt[k]    <= '0;
        shadow[k] <= '0;
      end
      ovf_o        <= '0;
      snap_valid_o <= 1'b0;
      rd_valid_o   <= 1'b0;
      rd_data_o    <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        // Shadow takes the register value before this edge's clear/increment.
        if (snap_i) begin
          shadow[k] <= cnt[k];
        end
        if (clear_i) begin
          cnt[k]   <= '0;
          ovf_o[k] <= 1'b0;
        end else if (enable_i && evt_i[k]) begin
          if (cnt[k] != '1) begin
            cnt[k] <= cnt[k] + CNT_W'(1);
          end else begin
            ovf_o[k] <= 1'b1;
            if (SAT_MODE == 0) begin
              cnt[k] <= '0;
            end
          end
        end
      end

      if (snap_i) begin
        snap_valid_o <= 1'b1;
      end else if (clear_i) begin
        snap_valid_o <= 1'b0;
      end

      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        rd_data_o <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_cache_perf_counters.sv
// Scoreboard bench for cache_perf_counters: saturating, wrapping and 3-channel
// instances driven by shared stimulus and compared against a behavioural model.
module tb_cache_perf_counters;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] evt;
  logic       en, clr, snp, rd_en, rd_src;
  logic [1:0] rd_sel;

  logic [7:0] rd_data0, rd_data1, rd_data2;
  logic       rd_valid0, rd_valid1, rd_valid2;
  logic [3:0] ovf0, ovf1;
  logic [2:0] ovf2;
  logic       sv0, sv1, sv2;

  always #5 clk = ~clk;

  cache_perf_counters #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .evt_i(evt), .enable_i(en), .clear_i(clr),
    .snap_i(snp), .rd_en_i(rd_en), .rd_src_i(rd_src), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .ovf_o(ovf0), .snap_valid_o(sv0)
  );

  cache_perf_counters #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .evt_i(evt), .enable_i(en), .clear_i(clr),
    .snap_i(snp), .rd_en_i(rd_en), .rd_src_i(rd_src), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .ovf_o(ovf1), .snap_valid_o(sv1)
  );

  cache_perf_counters #(.NUM_CH(3), .CNT_W(8), .SAT_MODE(1)) u_ch3 (
    .clk_i(clk), .rst_i(rst), .evt_i(evt[2:0]), .enable_i(en), .clear_i(clr),
    .snap_i(snp), .rd_en_i(rd_en), .rd_src_i(rd_src), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data2), .rd_valid_o(rd_valid2), .ovf_o(ovf2), .snap_valid_o(sv2)
  );

  logic       vld [3];
  logic [7:0] dat [3];
  assign vld[0] = rd_valid0;
  assign vld[1] = rd_valid1;
  assign vld[2] = rd_valid2;
  assign dat[0] = rd_data0;
  assign dat[1] = rd_data1;
  assign dat[2] = rd_data2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: instance 0 saturating/4ch, 1 wrapping/4ch, 2 saturating/3ch.
  int m_cnt [3][4];
  int m_sh  [3][4];
  bit m_ovf [3][4];
  bit m_sv  [3];

  typedef struct {
    int    due;
    int    d;
    int    data;
    string tag;
  } rd_exp_t;
  rd_exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Each read is popped on the valid pulse; its cycle stamp checks the latency.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vld[d]) begin
        if (sbq.size() == 0) begin
          check_eq("spurious_valid", 64'd1, 64'd0);
        end else begin
          rd_exp_t e;
          e = sbq.pop_front();
          check_eq("rd_dut_order", 64'(d), 64'(e.d));
          check_eq("rd_latency", 64'(cyc), 64'(e.due));
          check_eq(e.tag, 64'(dat[d]), 64'(e.data));
        end
      end
    end
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      rd_exp_t e;
      e = sbq.pop_front();
      check_eq({"rd_missing_", e.tag}, 64'd0, 64'd1);
    end
  end

  task automatic step(input logic r, input logic [3:0] ev, input logic e,
                      input logic cl, input logic sn, input logic rd,
                      input logic src, input logic [1:0] sel, input string tag = "rd");
    @(negedge clk);
    #1;
    rst = r; evt = ev; en = e; clr = cl; snp = sn;
    rd_en = rd; rd_src = src; rd_sel = sel;
    for (int d = 0; d < 3; d++) begin
      int  nch;
      bit  sat;
      nch = (d == 2) ? 3 : 4;
      sat = (d != 1);
      if (r) begin
        for (int k = 0; k < 4; k++) begin
          m_cnt[d][k] = 0; m_sh[d][k] = 0; m_ovf[d][k] = 1'b0;
        end
        m_sv[d] = 1'b0;
      end else begin
        if (rd) begin
          rd_exp_t x;
          x.due  = cyc + 1;
          x.d    = d;
          x.tag  = $sformatf("%s_dut%0d", tag, d);
          x.data = (int'(sel) < nch) ? (src ? m_sh[d][sel] : m_cnt[d][sel]) : 0;
          sbq.push_back(x);
        end
        for (int k = 0; k < nch; k++) begin
          if (sn) m_sh[d][k] = m_cnt[d][k];
          if (cl) begin
            m_cnt[d][k] = 0;
            m_ovf[d][k] = 1'b0;
          end else if (e && ev[k]) begin
            if (m_cnt[d][k] != 255) m_cnt[d][k] = m_cnt[d][k] + 1;
            else begin
              m_ovf[d][k] = 1'b1;
              m_cnt[d][k] = sat ? 255 : 0;
            end
          end
        end
        if (sn) m_sv[d] = 1'b1;
        else if (cl) m_sv[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; evt = '0; clr = 1'b0; snp = 1'b0; rd_en = 1'b0;
  endtask

  function automatic logic [3:0] model_ovf(input int d);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_ovf[d][k];
    return v;
  endfunction

  task automatic chk_flags(input string tag);
    check_eq({tag, "_ovf_dut0"}, 64'(ovf0), 64'(model_ovf(0)));
    check_eq({tag, "_ovf_dut1"}, 64'(ovf1), 64'(model_ovf(1)));
    check_eq({tag, "_ovf_dut2"}, 64'({1'b0, ovf2}), 64'(model_ovf(2)));
    check_eq({tag, "_snapv_dut0"}, 64'(sv0), 64'(m_sv[0]));
    check_eq({tag, "_snapv_dut1"}, 64'(sv1), 64'(m_sv[1]));
    check_eq({tag, "_snapv_dut2"}, 64'(sv2), 64'(m_sv[2]));
  endtask

  task automatic chk_rd_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("%s_rdvalid_dut%0d", tag, d), 64'(vld[d]), 64'd0);
      check_eq($sformatf("%s_rddata_dut%0d", tag, d), 64'(dat[d]), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; evt = '0; en = 1'b0; clr = 1'b0; snp = 1'b0;
    rd_en = 1'b0; rd_src = 1'b0; rd_sel = '0;

    repeat (3) step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_flags("reset");
    chk_rd_zero("reset");

    // Basic count and back-to-back live reads
    repeat (10) step(1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "live_ch0");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, "live_ch1");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, "live_ch2");
    chk_flags("count");

    // 258 events on ch3: saturate at 255 / wrap to 2; 3-channel instance reads 0
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (258) step(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_flags("satwrap");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, "ovf_ch3");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, "oor_shadow_ch3");

    // Snapshot excludes an event arriving in the same cycle
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (7) step(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, "snap_shadow_ch0");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "snap_live_ch0");
    chk_flags("snap");

    // Clear and snap together: shadow keeps pre-clear values, flag ends set
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (256) step(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ev;
      for (int k = 0; k < 4; k++) ev[k] = (i < 5 + k);
      step(1'b0, ev, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    chk_flags("pre_collide");
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    chk_flags("collide");
    for (int k = 0; k < 4; k++)
      step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'(k), $sformatf("coll_shadow_ch%0d", k));
    for (int k = 0; k < 4; k++)
      step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'(k), $sformatf("coll_live_ch%0d", k));

    // Clear alone drops the snapshot flag but keeps shadow contents
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_flags("clear_only");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, "kept_shadow_ch2");

    // Enable low freezes counting; read data holds when rd_en is low
    repeat (3) step(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (5) step(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, "frozen_ch1");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("hold_rddata_dut%0d", d), 64'(dat[d]), 64'd3);
      check_eq($sformatf("hold_rdvalid_dut%0d", d), 64'(vld[d]), 64'd0);
    end

    // Reset coinciding with a read: no valid pulse, everything zero
    step(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, "rst_read");
    chk_flags("rst_mid_read");
    chk_rd_zero("rst_mid_read");
    repeat (3) step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, "post_rst_shadow_ch0");
    repeat (3) step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    check_eq("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_perf_counters.md
Name: cache_perf_counters

Overview:
- Parametrised multi-channel event-counter bank for the L1 cache subsystem.
- Counts per-cycle event strobes such as access, hit, miss, writeback and command.
- Provides a live/shadow snapshot and a registered read port for the top level and benches.
- Replaces the single fixed-width hit/miss/access counters with N channels, configurable width, and selectable saturate or wrap mode with sticky overflow.

Parameters:
NUM_CH, 4, number of independent event channels (1..16)
CNT_W, 32, counter width in bits (8..64)
SAT_MODE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to zero
SEL_W, $clog2(NUM_CH) (min 1), width of the read-select field

Ports:
clk_i  in  1  clock, rising-edge
rst_i  in  1  synchronous reset, active-high
evt_i  in  NUM_CH  per-channel event strobe, counted once per cycle when high
enable_i  in  1  global count enable
clear_i  in  1  zero all live counters and overflow flags
snap_i  in  1  copy all live counters into shadow registers
rd_en_i  in  1  read request
rd_src_i  in  1  0 = read live counter, 1 = read shadow counter
rd_sel_i  in  SEL_W  channel index to read
rd_data_o  out  CNT_W  read data, registered
rd_valid_o  out  1  one-cycle pulse, qualifies rd_data_o
ovf_o  out  NUM_CH  sticky per-channel overflow/saturation flag
snap_valid_o  out  1  high once at least one snapshot has been taken since reset/clear

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Clock/reset ports are clk_i and rst_i.
- Reset (rst_i high at a rising edge) forces:
  - all live and shadow counters = 0
  - ovf_o = 0
  - snap_valid_o = 0, rd_valid_o = 0, rd_data_o = 0
- rst_i overrides every other input in the same cycle, including mid-read: no rd_valid_o pulse follows a read that coincides with reset.
- Live counter update per channel k, evaluated each edge in priority order:
  - clear_i = 1: cnt[k] <= 0, ovf[k] <= 0.
  - else if enable_i && evt_i[k]:
    - cnt[k] != all-ones: cnt[k] <= cnt[k] + 1.
    - cnt[k] == all-ones, SAT_MODE=1: cnt[k] holds at all-ones, ovf[k] <= 1.
    - cnt[k] == all-ones, SAT_MODE=0: cnt[k] <= 0, ovf[k] <= 1.
  - else: hold.
- ovf[k] is sticky; only clear_i or rst_i resets it.
- All channels update in parallel; simultaneous events on every channel are all counted.
- Snapshot:
  - snap_i = 1: shadow[k] <= cnt[k] for all k, using the pre-update (current register) value. An event in the same cycle is therefore not included in that snapshot.
  - snap_valid_o <= 1 on snap_i.
- snap_i and clear_i in the same cycle:
  - shadow captures the pre-clear values.
  - live counters and ovf go to 0.
  - snap_valid_o ends at 1 (snap takes precedence over clear for this flag).
- clear_i alone: snap_valid_o <= 0; shadow registers are retained.
- Read, fixed latency 1:
  - rd_en_i = 1 at edge T: rd_valid_o = 1 for the cycle after T.
  - rd_data_o = selected register value as it stood before edge T, i.e. same-cycle updates are not visible.
  - rd_sel_i >= NUM_CH returns 0 with rd_valid_o still asserted.
  - rd_en_i = 0: rd_valid_o <= 0; rd_data_o holds its last value.
  - Back-to-back reads on consecutive cycles are supported at full throughput.
- enable_i = 0 freezes counting only; clear, snap and read remain functional.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, count, read live:
  - Stimulus: reset 3 cycles, then enable_i=1, evt_i=4'b0101 for 10 cycles, then read live ch0/ch1/ch2.
  - Required: rd_data_o = 10, 0, 10, each with rd_valid_o exactly 1 cycle after rd_en_i.
- Saturation, SAT_MODE=1:
  - Stimulus: CNT_W=8, 300 events on ch3.
  - Required: cnt=255, ovf_o[3]=1; other ovf bits 0.
- Wrap, SAT_MODE=0:
  - Stimulus: CNT_W=8, 258 events on ch3.
  - Required: cnt=2, ovf_o[3]=1.
- Snapshot atomicity:
  - Stimulus: ch0 live=7; assert snap_i together with evt_i[0]; then read shadow and live.
  - Required: shadow=7, live=8, snap_valid_o=1.
- Clear+snap collision:
  - Stimulus: counters at 5/6/7/8 with ovf_o=4'b0010; assert clear_i and snap_i together.
  - Required: shadow=5/6/7/8, live=0, ovf_o=0, snap_valid_o=1.
- Out-of-range and reset mid-read:
  - Stimulus: NUM_CH=3, read rd_sel_i=3.
  - Required: rd_data_o=0, rd_valid_o=1.
  - Stimulus: rd_en_i asserted together with rst_i.
  - Required: rd_valid_o stays 0; all outputs 0.
